// File: rtl/game_time_ctrl.sv
// Game timer: synchronized start/stop/end buttons drive a four-state FSM and a
// prescaled three-digit BCD count. GAME_BEST_TIME_EN adds best-finish-time tracking.
module game_time_ctrl #(
  parameter int unsigned TICK_LST = 49_999_999
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic        i_Stop,
  input  logic        i_End,
  output logic [3:0]  o_Bcd0,
  output logic [3:0]  o_Bcd1,
  output logic [3:0]  o_Bcd2,
  output logic [1:0]  o_State,
  output logic        o_Timeout,
  output logic [11:0] o_BestBcd,
  output logic        o_NewBest
);

  localparam int unsigned PW = (TICK_LST > 0) ? $clog2(TICK_LST + 1) : 1;
  localparam logic [PW-1:0] PRE_LST = PW'(TICK_LST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t          state_q, state_n;
  logic [11:0]     cnt_q, cnt_n, cnt_inc;
  logic [PW-1:0]   presc_q, presc_n;
  logic            timeout_q, timeout_n;
  logic            tick;

  // Button bit order: {End, Stop, Start}
  logic [2:0] sync_a, sync_b, sync_q, evt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_a <= '0;
      sync_b <= '0;
      sync_q <= '0;
    end else begin
      sync_a <= {i_End, i_Stop, i_Start};
      sync_b <= sync_a;
      sync_q <= sync_b;
    end
  end

  assign evt = sync_b & ~sync_q;

  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q[3:0] == 4'd9) begin
      cnt_inc[3:0] = 4'd0;
      if (cnt_q[7:4] == 4'd9) begin
        cnt_inc[7:4]  = 4'd0;
        cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
      end else begin
        cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
      end
    end else begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end
  end

  assign tick = (state_q == RUN) && (presc_q == PRE_LST);

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    presc_n   = presc_q;
    timeout_n = timeout_q;
    unique case (state_q)
      IDLE: begin
        cnt_n     = '0;
        presc_n   = '0;
        timeout_n = 1'b0;
        if (evt[0]) state_n = RUN;
      end
      RUN: begin
        presc_n = tick ? '0 : presc_q + 1'b1;
        // End outranks both the tick and saturation, freezing the pre-tick count
        if (evt[2]) begin
          state_n = OVER;
        end else if (tick && cnt_q == 12'h999) begin
          state_n   = OVER;
          timeout_n = 1'b1;
        end else begin
          if (tick)   cnt_n   = cnt_inc;
          if (evt[1]) state_n = PAUSE;
        end
      end
      PAUSE: begin
        if (evt[1]) begin
          state_n = IDLE;
          cnt_n   = '0;
          presc_n = '0;
        end else if (evt[0]) begin
          state_n = RUN;
        end
      end
      OVER: begin
        presc_n = '0;
        if (evt[0]) begin
          state_n   = IDLE;
          cnt_n     = '0;
          timeout_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      presc_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      presc_q   <= presc_n;
      timeout_q <= timeout_n;
    end
  end

  assign o_Bcd0    = cnt_q[3:0];
  assign o_Bcd1    = cnt_q[7:4];
  assign o_Bcd2    = cnt_q[11:8];
  assign o_State   = state_q;
  assign o_Timeout = timeout_q;

`ifdef GAME_BEST_TIME_EN
  logic [11:0] best_q;
  logic        best_vld_q;
  logic        new_best_q;
  logic        end_win;

  // BCD digits compare correctly as a plain 12-bit number
  assign end_win = (state_q == RUN) && evt[2];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      best_q     <= '0;
      best_vld_q <= 1'b0;
      new_best_q <= 1'b0;
    end else begin
      new_best_q <= 1'b0;
      if (end_win && (!best_vld_q || cnt_q < best_q)) begin
        best_q     <= cnt_q;
        best_vld_q <= 1'b1;
        new_best_q <= 1'b1;
      end
    end
  end

  assign o_BestBcd = best_q;
  assign o_NewBest = new_best_q;
`else
  assign o_BestBcd = '0;
  assign o_NewBest = 1'b0;
`endif

endmodule

// File: tb/tb_game_time_ctrl.sv
// Directed bench for game_time_ctrl (TICK_LST=3) with a queue scoreboard of expected values.
module tb_game_time_ctrl;

  localparam int unsigned TL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, fin = 1'b0;
  logic [3:0]  bcd0, bcd1, bcd2;
  logic [1:0]  state;
  logic        timeout;
  logic [11:0] best;
  logic        new_best;

  game_time_ctrl #(.TICK_LST(TL)) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Start   (start),
    .i_Stop    (stop),
    .i_End     (fin),
    .o_Bcd0    (bcd0),
    .o_Bcd1    (bcd1),
    .o_Bcd2    (bcd2),
    .o_State   (state),
    .o_Timeout (timeout),
    .o_BestBcd (best),
    .o_NewBest (new_best)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [11:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic push(input string tag, input logic [11:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [11:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic exp_status(input string tag, input logic [1:0] st,
                            input logic to, input logic [11:0] bcd);
    push({tag, "_state"},   {10'd0, st});
    push({tag, "_timeout"}, {11'd0, to});
    push({tag, "_bcd"},     bcd);
  endtask

  task automatic cmp_status();
    pop_cmp({10'd0, state});
    pop_cmp({11'd0, timeout});
    pop_cmp({bcd2, bcd1, bcd0});
  endtask

  task automatic exp_best(input string tag, input logic [11:0] b, input logic nb);
`ifdef GAME_BEST_TIME_EN
    push({tag, "_best"},    b);
    push({tag, "_newbest"}, {11'd0, nb});
`else
    push({tag, "_best"},    12'h000);
    push({tag, "_newbest"}, 12'h000);
`endif
  endtask

  task automatic cmp_best();
    pop_cmp(best);
    pop_cmp({11'd0, new_best});
  endtask

  // Entered at a negedge; the FSM reacts on the third posedge, returns at the following negedge.
  task automatic press(input logic s, input logic p, input logic e, input int unsigned extra);
    start = s; stop = p; fin = e;
    repeat (3) @(posedge clk);
    repeat (extra) @(posedge clk);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; fin = 1'b0;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_status("reset", 2'd0, 1'b0, 12'h000); exp_best("reset", 12'h000, 1'b0);
    cmp_status(); cmp_best();

    // Game 1: count and carries
    press(1, 0, 0, 0);
    exp_status("start", 2'd1, 1'b0, 12'h000); cmp_status();
    run(36);  exp_status("c009", 2'd1, 1'b0, 12'h009); cmp_status();
    run(4);   exp_status("c010", 2'd1, 1'b0, 12'h010); cmp_status();
    run(116); exp_status("c039", 2'd1, 1'b0, 12'h039); cmp_status();
    run(4);   exp_status("c040", 2'd1, 1'b0, 12'h040); cmp_status();
    press(0, 1, 0, 0); exp_status("pause40", 2'd2, 1'b0, 12'h040); cmp_status();
    run(2);
    press(0, 1, 0, 0); exp_status("idle40", 2'd0, 1'b0, 12'h000); cmp_status();

    // Game 2: pause/resume at 025
    run(2);
    press(1, 0, 0, 0);
    run(100); exp_status("c025", 2'd1, 1'b0, 12'h025); cmp_status();
    press(0, 1, 0, 0); exp_status("pause25", 2'd2, 1'b0, 12'h025); cmp_status();
    run(100); exp_status("hold25", 2'd2, 1'b0, 12'h025); cmp_status();
    press(1, 0, 0, 0); exp_status("resume", 2'd1, 1'b0, 12'h025); cmp_status();
    run(1);   exp_status("c026", 2'd1, 1'b0, 12'h026); cmp_status();
    run(4);   exp_status("c027", 2'd1, 1'b0, 12'h027); cmp_status();
    press(1, 0, 0, 0); exp_status("run_start_ign", 2'd1, 1'b0, 12'h027); cmp_status();
    run(1);   exp_status("c028", 2'd1, 1'b0, 12'h028); cmp_status();
    press(0, 1, 0, 0); exp_status("pause28", 2'd2, 1'b0, 12'h028); cmp_status();
    run(2);
    press(1, 1, 0, 0); exp_status("both_is_stop", 2'd0, 1'b0, 12'h000); cmp_status();

    // Best-time games: 012, 008, 020
    run(2);
    press(1, 0, 0, 0);
    run(48);
    press(0, 0, 1, 0); exp_status("end12", 2'd3, 1'b0, 12'h012); exp_best("end12", 12'h012, 1'b1);
    cmp_status(); cmp_best();
    run(1); exp_best("end12_after", 12'h012, 1'b0); cmp_best();
    run(2); press(1, 0, 0, 0); exp_status("over_idle", 2'd0, 1'b0, 12'h000); cmp_status();
    run(2); press(1, 0, 0, 0);
    run(32);
    press(0, 0, 1, 0); exp_status("end08", 2'd3, 1'b0, 12'h008); exp_best("end08", 12'h008, 1'b1);
    cmp_status(); cmp_best();
    run(1); exp_best("end08_after", 12'h008, 1'b0); cmp_best();
    run(2); press(1, 0, 0, 0);
    run(2); press(1, 0, 0, 0);
    run(80);
    press(0, 0, 1, 0); exp_status("end20", 2'd3, 1'b0, 12'h020); exp_best("end20", 12'h008, 1'b0);
    cmp_status(); cmp_best();
    run(1); exp_best("end20_after", 12'h008, 1'b0); cmp_best();

    // Timeout game
    run(2); press(1, 0, 0, 0);
    run(2); press(1, 0, 0, 0);
    run(3996); exp_status("c999", 2'd1, 1'b0, 12'h999); cmp_status();
    run(3);    exp_status("c999_pre", 2'd1, 1'b0, 12'h999); cmp_status();
    run(1);    exp_status("timeout", 2'd3, 1'b1, 12'h999); exp_best("timeout", 12'h008, 1'b0);
    cmp_status(); cmp_best();
    run(20);   exp_status("to_hold", 2'd3, 1'b1, 12'h999); cmp_status();
    press(0, 1, 0, 0); exp_status("over_stop_ign", 2'd3, 1'b1, 12'h999); cmp_status();
    run(2);
    press(0, 0, 1, 0); exp_status("over_end_ign", 2'd3, 1'b1, 12'h999); exp_best("over_end_ign", 12'h008, 1'b0);
    cmp_status(); cmp_best();
    run(2);
    press(1, 0, 0, 10); exp_status("to_clear_held", 2'd0, 1'b0, 12'h000); cmp_status();

    // End+Stop coinciding with a tick at 005
    run(2); press(1, 0, 0, 0);
    run(21); exp_status("c005", 2'd1, 1'b0, 12'h005); cmp_status();
    press(0, 1, 1, 0); exp_status("end_tick", 2'd3, 1'b0, 12'h005); exp_best("end_tick", 12'h005, 1'b1);
    cmp_status(); cmp_best();

    // Reset mid-run with Start held
    run(2); press(1, 0, 0, 0);
    run(2); press(1, 0, 0, 0);
    run(10);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0;
    exp_status("midrst", 2'd0, 1'b0, 12'h000); exp_best("midrst", 12'h000, 1'b0);
    cmp_status(); cmp_best();
    run(5); exp_status("midrst_after", 2'd0, 1'b0, 12'h000); cmp_status();

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
